// File: rtl/rf_pkg.sv
// Shared constants and types for the rf_sb register file and its scoreboard.
`default_nettype none

package rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NREGS_DEF  = 32;
  localparam int ADDR_W_DEF = 5;

  // Register 0 is hardwired to zero and can never be written or marked busy.
  localparam int R0 = 0;

  typedef logic [NREGS_DEF-1:0] busy_vec_t;

endpackage

`default_nettype wire

// File: rtl/rf_sb_if.sv
// Decode-side bus of rf_sb: two read ports with busy flags, writeback and issue.
`default_nettype none

interface rf_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic [ADDR_W-1:0] RSaddr;
  logic [ADDR_W-1:0] RTaddr;
  logic [DATA_W-1:0] RS;
  logic [DATA_W-1:0] RT;
  logic              RS_BUSY;
  logic              RT_BUSY;
  logic              WE;
  logic [ADDR_W-1:0] RDaddr;
  logic [DATA_W-1:0] RD;
  logic              ISSUE;
  logic [ADDR_W-1:0] ISSUEaddr;

  modport master (
    output RSaddr, RTaddr, WE, RDaddr, RD, ISSUE, ISSUEaddr,
    input  RS, RT, RS_BUSY, RT_BUSY
  );

  modport slave (
    input  RSaddr, RTaddr, WE, RDaddr, RD, ISSUE, ISSUEaddr,
    output RS, RT, RS_BUSY, RT_BUSY
  );

endinterface

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback.
`default_nettype none

module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              set_en,
  input  wire logic [ADDR_W-1:0] set_addr,
  input  wire logic              clr_en,
  input  wire logic [ADDR_W-1:0] clr_addr,
  input  wire logic [ADDR_W-1:0] addr_a,
  input  wire logic [ADDR_W-1:0] addr_b,
  output logic                   busy_a,
  output logic                   busy_b
);

  logic [NREGS-1:0] busy;
  logic             set_live;
  logic             clr_live;

  assign set_live = set_en && (set_addr != ADDR_W'(R0));
  assign clr_live = clr_en && (clr_addr != ADDR_W'(R0));

  // The set is applied last so a same-address issue overrides the writeback:
  // a newer producer is still outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clr_live) busy[clr_addr] <= 1'b0;
      if (set_live) busy[set_addr] <= 1'b1;
    end
  end

  assign busy_a = busy[addr_a];
  assign busy_b = busy[addr_b];

endmodule

`default_nettype wire

// File: rtl/rf_sb.sv
// 2-read/1-write register file with pending-write scoreboard; R0 reads zero, never busy.
// Optional same-cycle write-through when RF_BYPASS_EN is defined.
`default_nettype none

module rf_sb
  import rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  wire logic WCLK,
  input  wire logic RESET,
  rf_sb_if.slave    bus
);

  logic [DATA_W-1:0] mem [NREGS];
  logic              wr_live;
  logic [DATA_W-1:0] rs_stored;
  logic [DATA_W-1:0] rt_stored;
  logic              rs_busy_q;
  logic              rt_busy_q;

  assign wr_live = bus.WE && (bus.RDaddr != ADDR_W'(R0));

  always_ff @(posedge WCLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_live) begin
      mem[bus.RDaddr] <= bus.RD;
    end
  end

  rf_scoreboard #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (WCLK),
    .rst      (RESET),
    .set_en   (bus.ISSUE),
    .set_addr (bus.ISSUEaddr),
    .clr_en   (bus.WE),
    .clr_addr (bus.RDaddr),
    .addr_a   (bus.RSaddr),
    .addr_b   (bus.RTaddr),
    .busy_a   (rs_busy_q),
    .busy_b   (rt_busy_q)
  );

  assign rs_stored = (bus.RSaddr == ADDR_W'(R0)) ? '0 : mem[bus.RSaddr];
  assign rt_stored = (bus.RTaddr == ADDR_W'(R0)) ? '0 : mem[bus.RTaddr];

`ifdef RF_BYPASS_EN
  logic rs_hit;
  logic rt_hit;
  logic rs_reissue;
  logic rt_reissue;

  assign rs_hit     = wr_live && (bus.RDaddr == bus.RSaddr);
  assign rt_hit     = wr_live && (bus.RDaddr == bus.RTaddr);
  assign rs_reissue = bus.ISSUE && (bus.ISSUEaddr == bus.RSaddr);
  assign rt_reissue = bus.ISSUE && (bus.ISSUEaddr == bus.RTaddr);

  // A forwarded value is only "not busy" if no new producer issues to it now.
  assign bus.RS      = rs_hit ? bus.RD : rs_stored;
  assign bus.RT      = rt_hit ? bus.RD : rt_stored;
  assign bus.RS_BUSY = (rs_hit && !rs_reissue) ? 1'b0 : rs_busy_q;
  assign bus.RT_BUSY = (rt_hit && !rt_reissue) ? 1'b0 : rt_busy_q;
`else
  assign bus.RS      = rs_stored;
  assign bus.RT      = rt_stored;
  assign bus.RS_BUSY = rs_busy_q;
  assign bus.RT_BUSY = rt_busy_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_sb.sv
// Directed self-checking bench for rf_sb (default 32x32 and a 16-bit x 8 instance).
`default_nettype none

module tb_rf_sb;

  logic WCLK  = 1'b0;
  logic RESET = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 WCLK = ~WCLK;

  rf_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  rf_sb_if #(.DATA_W(16), .ADDR_W(3)) bus8 ();

  rf_sb #(.DATA_W(32), .NREGS(32), .ADDR_W(5)) dut (
    .WCLK  (WCLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  rf_sb #(.DATA_W(16), .NREGS(8), .ADDR_W(3)) dut8 (
    .WCLK  (WCLK),
    .RESET (RESET),
    .bus   (bus8.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 2 time units after the active edge.
  task automatic tick();
    @(posedge WCLK);
    #2;
  endtask

  initial begin
    bus.RSaddr = '0;  bus.RTaddr = '0;  bus.WE = 1'b0;  bus.RDaddr = '0;
    bus.RD = '0;      bus.ISSUE = 1'b0; bus.ISSUEaddr = '0;
    bus8.RSaddr = '0; bus8.RTaddr = '0; bus8.WE = 1'b0; bus8.RDaddr = '0;
    bus8.RD = '0;     bus8.ISSUE = 1'b0; bus8.ISSUEaddr = '0;

    // Reset state
    bus.RSaddr = 5'd5; bus.RTaddr = 5'd7;
    #3;
    chk("reset_rs", bus.RS, 32'h0);
    chk("reset_rs_busy", {31'b0, bus.RS_BUSY}, 32'h0);
    #4 RESET = 1'b0;

    // Write 5, visible next cycle
    tick();
    bus.WE = 1'b1; bus.RDaddr = 5'd5; bus.RD = 32'hDEADBEEF; bus.RSaddr = 5'd5;
    #1;
`ifdef RF_BYPASS_EN
    chk("wr5_same_cycle", bus.RS, 32'hDEADBEEF);
`else
    chk("wr5_same_cycle", bus.RS, 32'h0);
`endif
    tick();
    bus.WE = 1'b0;
    #1 chk("wr5_next_cycle", bus.RS, 32'hDEADBEEF);

    // Write to R0 is ignored
    bus.WE = 1'b1; bus.RDaddr = 5'd0; bus.RD = 32'hFFFFFFFF; bus.RSaddr = 5'd0; bus.RTaddr = 5'd0;
    tick();
    bus.WE = 1'b0;
    #1;
    chk("r0_rs", bus.RS, 32'h0);
    chk("r0_rt", bus.RT, 32'h0);

    // Issue 7 -> busy, writeback 7 -> clear
    bus.ISSUE = 1'b1; bus.ISSUEaddr = 5'd7; bus.RTaddr = 5'd7; bus.RSaddr = 5'd5;
    tick();
    bus.ISSUE = 1'b0;
    #1;
    chk("issue7_rt_busy", {31'b0, bus.RT_BUSY}, 32'h1);
    chk("issue7_rs5_idle", {31'b0, bus.RS_BUSY}, 32'h0);
    bus.WE = 1'b1; bus.RDaddr = 5'd7; bus.RD = 32'h00000077;
    tick();
    bus.WE = 1'b0;
    #1;
    chk("wb7_rt_busy", {31'b0, bus.RT_BUSY}, 32'h0);
    chk("wb7_rt", bus.RT, 32'h00000077);

    // Issue to R0 never marks busy
    bus.ISSUE = 1'b1; bus.ISSUEaddr = 5'd0; bus.RSaddr = 5'd0;
    tick();
    bus.ISSUE = 1'b0;
    #1 chk("issue0_busy", {31'b0, bus.RS_BUSY}, 32'h0);

    // Same-cycle issue and writeback to 9: issue wins, data still written
    bus.ISSUE = 1'b1; bus.ISSUEaddr = 5'd9; bus.WE = 1'b1; bus.RDaddr = 5'd9;
    bus.RD = 32'h00000099; bus.RSaddr = 5'd9; bus.RTaddr = 5'd9;
    tick();
    bus.ISSUE = 1'b0; bus.WE = 1'b0;
    #1;
    chk("iss_wb9_rs_busy", {31'b0, bus.RS_BUSY}, 32'h1);
    chk("iss_wb9_rt_busy", {31'b0, bus.RT_BUSY}, 32'h1);
    chk("iss_wb9_data", bus.RS, 32'h00000099);

    // Write 3 and mark it busy, then a second writeback to 3 observed in-cycle
    bus.WE = 1'b1; bus.RDaddr = 5'd3; bus.RD = 32'hAAAA0003;
    bus.ISSUE = 1'b1; bus.ISSUEaddr = 5'd3;
    tick();
    bus.ISSUE = 1'b0;
    bus.RD = 32'h12345678; bus.RSaddr = 5'd3; bus.RTaddr = 5'd3;
    #1;
`ifdef RF_BYPASS_EN
    chk("byp3_rs", bus.RS, 32'h12345678);
    chk("byp3_rt", bus.RT, 32'h12345678);
    chk("byp3_rs_busy", {31'b0, bus.RS_BUSY}, 32'h0);
    chk("byp3_rt_busy", {31'b0, bus.RT_BUSY}, 32'h0);
`else
    chk("byp3_rs", bus.RS, 32'hAAAA0003);
    chk("byp3_rt", bus.RT, 32'hAAAA0003);
    chk("byp3_rs_busy", {31'b0, bus.RS_BUSY}, 32'h1);
    chk("byp3_rt_busy", {31'b0, bus.RT_BUSY}, 32'h1);
`endif
    tick();
    bus.WE = 1'b0;
    #1;
    chk("wr3_after", bus.RS, 32'h12345678);
    chk("wr3_after_busy", {31'b0, bus.RS_BUSY}, 32'h0);

    // Re-issue 3, then writeback and issue to 3 together
    bus.ISSUE = 1'b1; bus.ISSUEaddr = 5'd3;
    tick();
    bus.WE = 1'b1; bus.RDaddr = 5'd3; bus.RD = 32'h00000055;
    #1;
    chk("reiss3_busy", {31'b0, bus.RS_BUSY}, 32'h1);
`ifdef RF_BYPASS_EN
    chk("reiss3_rs", bus.RS, 32'h00000055);
`else
    chk("reiss3_rs", bus.RS, 32'h12345678);
`endif
    tick();
    bus.WE = 1'b0; bus.ISSUE = 1'b0;
    #1;
    chk("reiss3_after_busy", {31'b0, bus.RS_BUSY}, 32'h1);
    chk("reiss3_after_rs", bus.RS, 32'h00000055);

    // Asynchronous reset mid-run, with a write pending that must be dropped
    bus.RSaddr = 5'd5; bus.RTaddr = 5'd3;
    RESET = 1'b1;
    #1;
    chk("mid_reset_rs", bus.RS, 32'h0);
    chk("mid_reset_rt", bus.RT, 32'h0);
    chk("mid_reset_rt_busy", {31'b0, bus.RT_BUSY}, 32'h0);
    bus.WE = 1'b1; bus.RDaddr = 5'd5; bus.RD = 32'h11111111;
    tick();
    RESET = 1'b0; bus.WE = 1'b0;
    #1;
    chk("post_reset_rs", bus.RS, 32'h0);
    chk("post_reset_rs_busy", {31'b0, bus.RS_BUSY}, 32'h0);

    // 16-bit x 8 instance: R0 write ignored, walking ones in 1..7
    bus8.WE = 1'b1; bus8.RDaddr = 3'd0; bus8.RD = 16'hFFFF;
    tick();
    for (int i = 1; i < 8; i++) begin
      bus8.RDaddr = 3'(i);
      bus8.RD     = 16'(1) << i;
      tick();
    end
    bus8.WE = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus8.RSaddr = 3'(i);
      bus8.RTaddr = 3'(7 - i);
      #1;
      chk($sformatf("p8_rs%0d", i), {16'b0, bus8.RS}, (i == 0) ? 32'h0 : (32'h1 << i));
      chk($sformatf("p8_rt%0d", 7 - i), {16'b0, bus8.RT}, (i == 7) ? 32'h0 : (32'h1 << (7 - i)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
